lutram_mw_1r: RTL and testbench
===============================

# lutram_mw_1r

Multi-write-port, single-read-port LUTRAM that complements the existing 1-write/multi-read LUTRAM in the register-file and tracking-table paths. It accepts up to NUM_WRITE_PORTS independent writes per cycle. Each write port has its own 1w1r LUTRAM bank. A live-value table (LVT) records which bank holds the newest value for every address. After reset, an internal sweep zeroes the contents, and `init_done` signals when the RAM is ready to use.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of entries; power of two, ≥ 2
- NUM_WRITE_PORTS, 2, number of write ports; ≥ 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- waddr  in  [NUM_WRITE_PORTS] × $clog2(DEPTH)  write addresses
- ram_write  in  NUM_WRITE_PORTS  per-port write enable
- new_ram_data  in  [NUM_WRITE_PORTS] × WIDTH  write data
- raddr  in  $clog2(DEPTH)  read address
- ram_data_out  out  WIDTH  read data, combinational from raddr
- init_done  out  1  high once the post-reset clear sweep completes

## Operation
- Storage:
  - One `lutram_1w_1r` bank per write port.
  - Bank w is written only by port w.
  - Every bank is read at raddr.
- LVT:
  - Register array of DEPTH × $clog2(NUM_WRITE_PORTS) bits.
  - On a write from port w to address a, LVT[a] ← w.
  - Read data is bank[LVT[raddr]][raddr].
- Same-address collision: when several ports write the same address in one cycle, the highest-indexed port wins. All banks are still written, but LVT records the highest index.
- Clear FSM states: CLEARING and READY.
  - rst → CLEARING, with clear counter = 0.
  - CLEARING: each cycle writes 0 to bank 0 at the counter address, sets LVT[counter] ← 0, and increments the counter.
  - When counter = DEPTH−1 has been written → READY.
  - READY is absorbing until the next rst.
- External writes are ignored while CLEARING.
- ram_data_out is forced to 0 while CLEARING.
- Counter width is $clog2(DEPTH). The counter is not allowed to wrap; the transition to READY happens on the DEPTH−1 write.
- Reset asserted mid-sweep or in READY restarts the sweep from address 0.

## Timing
- Reset values: init_done = 0, FSM = CLEARING, counter = 0, ram_data_out = 0.
- Clear duration: rst deasserts on edge E. Addresses 0..DEPTH−1 are written on edges E+1..E+DEPTH, and init_done goes high after edge E+DEPTH.
- Write latency: a write presented in cycle N is visible on ram_data_out in cycle N+1. Bank and LVT are both updated on the same edge.
- Read latency: zero cycles (asynchronous LUTRAM read).
- A read and a write to the same address in one cycle return the old value, unless bypass is enabled (see Configuration).

## Configuration
- Macro: LUTRAM_MW_WRITE_BYPASS_EN.
- Defined:
  - A same-cycle write to raddr is forwarded to ram_data_out.
  - Among multiple writers to raddr, the highest-indexed port's data is forwarded.
  - Bypass is inactive while CLEARING.
- Undefined: no forwarding; read-during-write returns the pre-write value.

## Structure
- Existing shared package taiga_config:
  - FPGA_VENDOR is used unchanged.
  - The clear-FSM state enum (CLEARING, READY) goes in this package.
- Sub-module: `lutram_1w_1r`, instantiated NUM_WRITE_PORTS times in a generate loop.
- LVT, collision priority encoder, clear FSM and bypass mux live inline in this block.

## Test plan
- Reset then read all addresses: init_done low for exactly DEPTH cycles after rst deasserts, then high; every address reads 0x0.
- Port 0 writes addr 3 = 0xAAAA_0001, next cycle port 1 writes addr 3 = 0xBBBB_0002: addr 3 reads 0xAAAA_0001, then 0xBBBB_0002.
- Ports 0 and 1 both write addr 7 (0x11, 0x22) in the same cycle: addr 7 reads 0x22 the next cycle.
- Ports 0 and 1 write addr 1 = 0x5 and addr 2 = 0x6 in the same cycle: both reads return the written values.
- Writes issued during CLEARING to addr 4 = 0xFF: addr 4 reads 0 after init_done.
- Bypass: with LUTRAM_MW_WRITE_BYPASS_EN, raddr = 9 while port 1 writes 0x1234 to addr 9 → 0x1234 the same cycle. Without the macro → old value (0).
- rst asserted at sweep cycle 5: init_done stays 0 and rises DEPTH cycles after the new deassert.

Source files
------------

// File: rtl/taiga_config.sv
// rtl/taiga_config.sv - shared configuration package: target vendor and LUTRAM clear-FSM states
package taiga_config;

    typedef enum logic [1:0] {
        XILINX,
        INTEL
    } vendor_t;

    localparam vendor_t FPGA_VENDOR = XILINX;

    typedef enum logic {
        CLEARING,
        READY
    } lutram_clear_state_t;

endpackage

// File: rtl/lutram_1w_1r.sv
// rtl/lutram_1w_1r.sv - single-write, single-read LUTRAM bank with asynchronous read
module lutram_1w_1r #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic                     ram_write,
    input  logic [WIDTH-1:0]         new_ram_data,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         ram_data_out
);

    // No reset: contents are cleared by the owner's post-reset sweep.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (ram_write)
            mem_q[waddr] <= new_ram_data;
    end

    assign ram_data_out = mem_q[raddr];

endmodule

// File: rtl/lutram_mw_1r.sv
// rtl/lutram_mw_1r.sv - multi-write/single-read LUTRAM using an LVT; LUTRAM_MW_WRITE_BYPASS_EN enables write forwarding
module lutram_mw_1r
    import taiga_config::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEPTH           = 32,
    parameter int NUM_WRITE_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(DEPTH)-1:0]   waddr [NUM_WRITE_PORTS],
    input  logic [NUM_WRITE_PORTS-1:0] ram_write,
    input  logic [WIDTH-1:0]           new_ram_data [NUM_WRITE_PORTS],
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           ram_data_out,
    output logic                       init_done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVT_W  = $clog2(NUM_WRITE_PORTS);

    lutram_clear_state_t state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [LVT_W-1:0]    lvt_q [DEPTH];
    logic [LVT_W-1:0]    lvt_d [DEPTH];
    logic                clearing;

    logic [NUM_WRITE_PORTS-1:0] bank_we;
    logic [ADDR_W-1:0]          bank_waddr [NUM_WRITE_PORTS];
    logic [WIDTH-1:0]           bank_wdata [NUM_WRITE_PORTS];
    logic [WIDTH-1:0]           bank_rdata [NUM_WRITE_PORTS];
    logic [WIDTH-1:0]           read_data;

    assign clearing  = (state_q == CLEARING);
    assign init_done = (state_q == READY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEARING) begin
            // Counter holds at DEPTH-1 rather than wrapping; READY takes over.
            if (cnt_q == ADDR_W'(DEPTH - 1))
                state_d = READY;
            else
                cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEARING;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            bank_we[w]    = ram_write[w] & ~clearing;
            bank_waddr[w] = waddr[w];
            bank_wdata[w] = new_ram_data[w];
        end
        if (clearing) begin
            bank_we[0]    = 1'b1;
            bank_waddr[0] = cnt_q;
            bank_wdata[0] = '0;
        end
    end

    // Ascending loop: the highest-indexed writer of an address owns it.
    always_comb begin
        lvt_d = lvt_q;
        if (clearing) begin
            lvt_d[cnt_q] = '0;
        end else begin
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (ram_write[w])
                    lvt_d[waddr[w]] = LVT_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        lvt_q <= lvt_d;
    end

    for (genvar g = 0; g < NUM_WRITE_PORTS; g++) begin : g_bank
        lutram_1w_1r #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk          (clk),
            .waddr        (bank_waddr[g]),
            .ram_write    (bank_we[g]),
            .new_ram_data (bank_wdata[g]),
            .raddr        (raddr),
            .ram_data_out (bank_rdata[g])
        );
    end

    always_comb begin
        read_data = '0;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (lvt_q[raddr] == LVT_W'(w))
                read_data = bank_rdata[w];
        end
`ifdef LUTRAM_MW_WRITE_BYPASS_EN
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (ram_write[w] && (waddr[w] == raddr))
                read_data = new_ram_data[w];
        end
`endif
        ram_data_out = clearing ? '0 : read_data;
    end

endmodule

// File: tb/tb_lutram_mw_1r.sv
// tb/tb_lutram_mw_1r.sv - directed self-checking bench for lutram_mw_1r
module tb_lutram_mw_1r;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NWP   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    waddr [NWP];
    logic [NWP-1:0]   ram_write;
    logic [WIDTH-1:0] new_ram_data [NWP];
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] ram_data_out;
    logic             init_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lutram_mw_1r #(
        .WIDTH           (WIDTH),
        .DEPTH           (DEPTH),
        .NUM_WRITE_PORTS (NWP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .waddr        (waddr),
        .ram_write    (ram_write),
        .new_ram_data (new_ram_data),
        .raddr        (raddr),
        .ram_data_out (ram_data_out),
        .init_done    (init_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_ports();
        ram_write = '0;
        for (int w = 0; w < NWP; w++) begin
            waddr[w]        = '0;
            new_ram_data[w] = '0;
        end
    endtask

    // Waits for init_done with a cycle bound; returns number of low cycles seen.
    task automatic count_clear(output int low, input bit poke_writes);
        low = 0;
        while (!init_done && low < 4 * DEPTH) begin
            if (poke_writes && low < 3) begin
                ram_write[0]    = 1'b1;
                waddr[0]        = AW'(4);
                new_ram_data[0] = 32'hFF;
                raddr           = AW'(4);
            end else begin
                idle_ports();
            end
            @(posedge clk);
            #1;
            low++;
            if (low == 2)
                check("data_zero_while_clearing", ram_data_out, 32'h0);
        end
        idle_ports();
    endtask

    task automatic write_cycle(input logic en0, input logic [AW-1:0] a0, input logic [31:0] d0,
                               input logic en1, input logic [AW-1:0] a1, input logic [31:0] d1);
        ram_write       = {en1, en0};
        waddr[0]        = a0;
        waddr[1]        = a1;
        new_ram_data[0] = d0;
        new_ram_data[1] = d1;
        @(posedge clk);
        #1;
        idle_ports();
    endtask

    initial begin
        int low;
        logic [31:0] bypass_exp;

        rst   = 1'b1;
        raddr = '0;
        idle_ports();
        repeat (3) @(posedge clk);
        #1;
        check("reset_init_done", {31'b0, init_done}, 32'h0);
        check("reset_data_out", ram_data_out, 32'h0);
        rst = 1'b0;

        count_clear(low, 1'b1);
        check("clear_low_cycles", low, DEPTH);
        check("init_done_high", {31'b0, init_done}, 32'h1);

        for (int a = 0; a < DEPTH; a++) begin
            raddr = AW'(a);
            #1;
            check($sformatf("cleared_addr_%0d", a), ram_data_out, 32'h0);
        end

        raddr = AW'(3);
        write_cycle(1'b1, AW'(3), 32'hAAAA_0001, 1'b0, '0, 32'h0);
        check("p0_addr3", ram_data_out, 32'hAAAA_0001);
        write_cycle(1'b0, '0, 32'h0, 1'b1, AW'(3), 32'hBBBB_0002);
        check("p1_addr3", ram_data_out, 32'hBBBB_0002);

        raddr = AW'(7);
        write_cycle(1'b1, AW'(7), 32'h11, 1'b1, AW'(7), 32'h22);
        check("collision_addr7", ram_data_out, 32'h22);

        write_cycle(1'b1, AW'(1), 32'h5, 1'b1, AW'(2), 32'h6);
        raddr = AW'(1);
        #1;
        check("dual_addr1", ram_data_out, 32'h5);
        raddr = AW'(2);
        #1;
        check("dual_addr2", ram_data_out, 32'h6);

`ifdef LUTRAM_MW_WRITE_BYPASS_EN
        bypass_exp = 32'h1234;
`else
        bypass_exp = 32'h0;
`endif
        raddr           = AW'(9);
        ram_write       = 2'b10;
        waddr[1]        = AW'(9);
        new_ram_data[1] = 32'h1234;
        #1;
        check("bypass_same_cycle", ram_data_out, bypass_exp);
        @(posedge clk);
        #1;
        idle_ports();
        check("addr9_after_write", ram_data_out, 32'h1234);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_sweep_init_done", {31'b0, init_done}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rerst_init_done", {31'b0, init_done}, 32'h0);
        count_clear(low, 1'b0);
        check("reclear_low_cycles", low, DEPTH);
        raddr = AW'(3);
        #1;
        check("reclear_addr3", ram_data_out, 32'h0);
        raddr = AW'(9);
        #1;
        check("reclear_addr9", ram_data_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
